// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-basic control path.
package multicycle_ctrl_pkg;

  // ALU operation codes
  localparam logic [2:0] ALU_RTYPE = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'd1;
  localparam logic [2:0] ALU_SUB   = 3'd2;
  localparam logic [2:0] ALU_AND   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_LESS  = 3'd5;

  // opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_SUBI  = 6'b000011;
  localparam logic [5:0] OP_ANDI  = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b000101;
  localparam logic [5:0] OP_SLTI  = 6'b000111;
  localparam logic [5:0] OP_MOVE  = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b001001;
  localparam logic [5:0] OP_SW    = 6'b010000;
  localparam logic [5:0] OP_SB    = 6'b010001;
  localparam logic [5:0] OP_BEQ   = 6'b100011;
  localparam logic [5:0] OP_BNE   = 6'b100111;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JAL   = 6'b111001;

  // datapath mux encodings
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] REG_RT = 2'd0;
  localparam logic [1:0] REG_RD = 2'd1;
  localparam logic [1:0] REG_RA = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;
  localparam logic [1:0] WB_RS   = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM    = 4'd5,
    S_WB     = 4'd6,
    S_BRANCH = 4'd7,
    S_JUMP   = 4'd8,
    S_TRAP   = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    CL_EXEC, CL_MEM, CL_BRANCH, CL_JUMP, CL_ILLEGAL
  } op_class_t;

  // Coarse instruction class; selects the state that follows DECODE.
  function automatic op_class_t op_class(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_SUBI, OP_ANDI,
      OP_ORI, OP_SLTI, OP_MOVE:          return CL_EXEC;
      OP_LW, OP_LB, OP_SW, OP_SB:        return CL_MEM;
      OP_BEQ, OP_BNE:                    return CL_BRANCH;
      OP_J, OP_JAL:                      return CL_JUMP;
      default:                           return CL_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Wait-cycle counter for a pending memory request. Shared by the
// instruction fetch and data access waits, which never overlap.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic ready,
  output logic expired
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt;

  // Count request cycles without ready; a completed or idle wait restarts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt <= '0;
    else if (clear || ready || !enable)  cnt <= '0;
    else if (cnt != LAST)                cnt <= cnt + 1'b1;
  end

  // Fires in the TIMEOUT-th request cycle unless ready arrives in that cycle.
  assign expired = (TIMEOUT != 0) && enable && !ready && (cnt == LAST);
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back,
// drives datapath enables from state + registered opcode, traps on faults.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int ALUOP_W     = 3,
  parameter int TIMEOUT     = 16,
  parameter int ENABLE_BYTE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                dmem_byte,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          wb_sel,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                alu_src,
  output logic                trap,
  output logic [1:0]          trap_cause
);
  state_t              state;
  logic [OPCODE_W-1:0] opc_q;
  logic [1:0]          cause_q;
  logic [5:0]          op6;
  op_class_t           cls;
  logic                is_load, is_store, is_byte, is_rtype, is_move, is_jal, is_bne;
  logic                illegal, in_wait, wait_ready, expired;
  logic [2:0]          aop;

  assign op6      = 6'(opc_q);
  assign cls      = op_class(op6);
  assign is_load  = (op6 == OP_LW) || (op6 == OP_LB);
  assign is_store = (op6 == OP_SW) || (op6 == OP_SB);
  assign is_byte  = (op6 == OP_LB) || (op6 == OP_SB);
  assign is_rtype = (op6 == OP_RTYPE);
  assign is_move  = (op6 == OP_MOVE);
  assign is_jal   = (op6 == OP_JAL);
  assign is_bne   = (op6 == OP_BNE);
  assign illegal  = (cls == CL_ILLEGAL) || (is_byte && (ENABLE_BYTE == 0));

  assign in_wait    = (state == S_FETCH) || (state == S_MEM);
  assign wait_ready = (state == S_FETCH) ? imem_ready : dmem_ready;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!in_wait),
    .enable  (in_wait),
    .ready   (wait_ready),
    .expired (expired)
  );

  // Sequencer: state, captured opcode and sticky trap cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      opc_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            opc_q <= opcode;
            state <= S_DECODE;
          end else if (expired) begin
            state   <= S_TRAP;
            cause_q <= CAUSE_IMEM;
          end
        end
        S_DECODE: begin
          if (illegal) begin
            state   <= S_TRAP;
            cause_q <= CAUSE_ILLEGAL;
          end else begin
            case (cls)
              CL_EXEC:   state <= S_EXEC;
              CL_MEM:    state <= S_ADDR;
              CL_BRANCH: state <= S_BRANCH;
              default:   state <= S_JUMP;
            endcase
          end
        end
        S_EXEC: state <= S_WB;
        S_ADDR: state <= S_MEM;
        S_MEM: begin
          if (dmem_ready) begin
            state <= is_load ? S_WB : S_FETCH;
          end else if (expired) begin
            state   <= S_TRAP;
            cause_q <= CAUSE_DMEM;
          end
        end
        S_WB, S_BRANCH, S_JUMP: state <= S_FETCH;
        S_TRAP: state <= S_TRAP;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign trap       = (state == S_TRAP);
  assign trap_cause = cause_q;
  assign alu_op     = ALUOP_W'(aop);

  // Datapath enables decoded from state and the registered opcode.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    dmem_byte = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    reg_write = 1'b0;
    reg_dst   = REG_RT;
    wb_sel    = WB_ALU;
    aop       = ALU_RTYPE;
    alu_src   = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_EXEC: begin
        case (op6)
          OP_ADDI: begin aop = ALU_ADD;  alu_src = 1'b1; end
          OP_SUBI: begin aop = ALU_SUB;  alu_src = 1'b1; end
          OP_ANDI: begin aop = ALU_AND;  alu_src = 1'b1; end
          OP_ORI:  begin aop = ALU_OR;   alu_src = 1'b1; end
          OP_SLTI: begin aop = ALU_LESS; alu_src = 1'b1; end
          OP_MOVE: aop = ALU_AND;
          default: aop = ALU_RTYPE;
        endcase
      end
      S_ADDR: begin
        aop     = ALU_ADD;
        alu_src = 1'b1;
      end
      S_MEM: begin
        dmem_req  = 1'b1;
        dmem_we   = is_store;
        dmem_byte = is_byte;
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_dst   = is_rtype ? REG_RD : REG_RT;
        wb_sel    = is_load ? WB_MEM : (is_move ? WB_RS : WB_ALU);
      end
      S_BRANCH: begin
        aop      = ALU_SUB;
        pc_write = alu_zero ^ is_bne;
        pc_src   = PC_BRANCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_JUMP;
        if (is_jal) begin
          reg_write = 1'b1;
          reg_dst   = REG_RA;
          wb_sel    = WB_LINK;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against an instruction-level model.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b1;
  logic [5:0] opcode = '0;
  logic       alu_zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic       imem_req, dmem_req, dmem_we, dmem_byte, ir_write, pc_write;
  logic [1:0] pc_src, reg_dst, wb_sel, trap_cause;
  logic       reg_write, alu_src, trap;
  logic [2:0] alu_op;
  logic [19:0] outs;

  int errs = 0, chks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.OPCODE_W(6), .ALUOP_W(3), .TIMEOUT(4), .ENABLE_BYTE(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_byte(dmem_byte),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_op(alu_op), .alu_src(alu_src),
    .trap(trap), .trap_cause(trap_cause)
  );

  assign outs = {imem_req, dmem_req, dmem_we, dmem_byte, ir_write, pc_write, pc_src,
                 reg_write, reg_dst, wb_sel, alu_op, alu_src, trap, trap_cause};

  // What one instruction did, summarised over its whole execution.
  typedef struct {
    int cyc; int icyc; int dcyc; int rw; int pcw;
    logic we; logic byt; logic fetch_ok; logic trap;
    logic [1:0] rdst; logic [1:0] wbs; logic [1:0] pcs; logic [1:0] cause;
    logic [2:0] aop; logic asrc;
  } obs_t;

  // Instruction-level expectations: cycle budget, memory traffic, effects.
  function automatic obs_t model(input logic [5:0] opc, input int iw, input int dw, input logic az);
    obs_t e;
    e = '{default:0};
    e.fetch_ok = 1'b1;
    e.icyc = iw + 1;
    case (opc)
      OP_RTYPE: begin e.cyc = iw + 4; e.rw = 1; e.rdst = 2'd1; e.aop = ALU_RTYPE; end
      OP_ADDI:  begin e.cyc = iw + 4; e.rw = 1; e.aop = ALU_ADD;  e.asrc = 1'b1; end
      OP_SUBI:  begin e.cyc = iw + 4; e.rw = 1; e.aop = ALU_SUB;  e.asrc = 1'b1; end
      OP_ANDI:  begin e.cyc = iw + 4; e.rw = 1; e.aop = ALU_AND;  e.asrc = 1'b1; end
      OP_ORI:   begin e.cyc = iw + 4; e.rw = 1; e.aop = ALU_OR;   e.asrc = 1'b1; end
      OP_SLTI:  begin e.cyc = iw + 4; e.rw = 1; e.aop = ALU_LESS; e.asrc = 1'b1; end
      OP_MOVE:  begin e.cyc = iw + 4; e.rw = 1; e.wbs = 2'd3; e.aop = ALU_AND; end
      OP_LW, OP_LB: begin
        e.cyc = iw + dw + 5; e.dcyc = dw + 1; e.rw = 1; e.wbs = 2'd1;
        e.aop = ALU_ADD; e.asrc = 1'b1; e.byt = (opc == OP_LB);
      end
      OP_SW, OP_SB: begin
        e.cyc = iw + dw + 4; e.dcyc = dw + 1; e.we = 1'b1;
        e.aop = ALU_ADD; e.asrc = 1'b1; e.byt = (opc == OP_SB);
      end
      OP_BEQ, OP_BNE: begin
        e.cyc = iw + 3; e.aop = ALU_SUB;
        e.pcw = (az ^ (opc == OP_BNE)) ? 1 : 0;
        e.pcs = (e.pcw != 0) ? 2'd1 : 2'd0;
      end
      default: begin // j / jal
        e.cyc = iw + 3; e.pcw = 1; e.pcs = 2'd2;
        if (opc == OP_JAL) begin e.rw = 1; e.rdst = 2'd2; e.wbs = 2'd2; end
      end
    endcase
    return e;
  endfunction

  // Drive one instruction from FETCH until the next FETCH (or a trap).
  // Memories answer after iw / dw wait cycles; entered and left at a negedge.
  task automatic run_instr(input logic [5:0] opc, input int iw, input int dw,
                           input logic az, output obs_t o);
    int icnt, dcnt, exec_at;
    bit fetched;
    o = '{default:0};
    o.fetch_ok = 1'b1;
    icnt = 0; dcnt = 0; exec_at = -1; fetched = 0;
    alu_zero = az;
    forever begin
      imem_ready = 1'b0; dmem_ready = 1'b0;
      if (imem_req) begin imem_ready = (icnt == iw); icnt++; end
      if (dmem_req) begin dmem_ready = (dcnt == dw); dcnt++; end
      opcode = imem_ready ? opc : 6'($urandom);
      #1;
      o.cyc++;
      if (imem_req) o.icyc++;
      if (dmem_req) begin o.dcyc++; o.we |= dmem_we; o.byt |= dmem_byte; end
      if (ir_write) begin
        fetched = 1; exec_at = o.cyc + 2;
        if (!(pc_write === 1'b1 && pc_src === PC_PLUS4)) o.fetch_ok = 1'b0;
      end else if (pc_write) begin
        o.pcw++; o.pcs = pc_src;
      end
      if (reg_write) begin o.rw++; o.rdst = reg_dst; o.wbs = wb_sel; end
      if (o.cyc == exec_at) begin o.aop = alu_op; o.asrc = alu_src; end
      o.trap = trap; o.cause = trap_cause;
      if (trap || o.cyc > 100) break;
      @(negedge clk);
      if (fetched && imem_req) break;
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; opcode = OP_JAL;
    repeat (2) @(negedge clk);
    #1;
    chks++; if (outs !== 20'd0) begin errs++; $display("FAIL reset_outs got=%h exp=0", outs); end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    chks++; if (outs !== 20'd0) begin errs++; $display("FAIL idle_outs got=%h exp=0", outs); end
    @(negedge clk); #1;
    chks++; if (outs !== 20'h80000) begin errs++; $display("FAIL first_fetch got=%h exp=80000", outs); end
  endtask

  task automatic test_add();
    obs_t o;
    run_instr(OP_RTYPE, 0, 0, 1'b0, o);
    chks++; if (o.cyc !== 4) begin errs++; $display("FAIL add_cycles got=%0d exp=4", o.cyc); end
    chks++; if ({o.rw, o.rdst, o.aop, o.trap} !== {32'd1, 2'd1, ALU_RTYPE, 1'b0})
      begin errs++; $display("FAIL add_wb got rw=%0d dst=%0d aop=%0d trap=%b", o.rw, o.rdst, o.aop, o.trap); end
    chks++; if (o.fetch_ok !== 1'b1) begin errs++; $display("FAIL add_fetch got=%b exp=1", o.fetch_ok); end
  endtask

  task automatic test_lb();
    obs_t o;
    run_instr(OP_LB, 0, 3, 1'b0, o);
    chks++; if (o.dcyc !== 4) begin errs++; $display("FAIL lb_dreq got=%0d exp=4", o.dcyc); end
    chks++; if ({o.byt, o.we} !== 2'b10) begin errs++; $display("FAIL lb_size got byte=%b we=%b exp 1/0", o.byt, o.we); end
    chks++; if (o.wbs !== 2'd1) begin errs++; $display("FAIL lb_wbsel got=%0d exp=1", o.wbs); end
    chks++; if (o.cyc !== 8) begin errs++; $display("FAIL lb_cycles got=%0d exp=8", o.cyc); end
  endtask

  task automatic test_branch();
    obs_t o;
    run_instr(OP_BNE, 0, 0, 1'b0, o);
    chks++; if ({o.pcw, o.pcs, o.cyc} !== {32'd1, 2'd1, 32'd3})
      begin errs++; $display("FAIL bne_taken got pcw=%0d src=%0d cyc=%0d exp 1/1/3", o.pcw, o.pcs, o.cyc); end
    run_instr(OP_BEQ, 0, 0, 1'b0, o);
    chks++; if ({o.pcw, o.cyc} !== {32'd0, 32'd3})
      begin errs++; $display("FAIL beq_not_taken got pcw=%0d cyc=%0d exp 0/3", o.pcw, o.cyc); end
  endtask

  task automatic test_jal();
    obs_t o;
    run_instr(OP_JAL, 0, 0, 1'b0, o);
    chks++; if ({o.pcw, o.pcs, o.rw, o.rdst, o.wbs, o.cyc} !== {32'd1, 2'd2, 32'd1, 2'd2, 2'd2, 32'd3})
      begin errs++; $display("FAIL jal got pcw=%0d src=%0d rw=%0d dst=%0d wb=%0d cyc=%0d", o.pcw, o.pcs, o.rw, o.rdst, o.wbs, o.cyc); end
  endtask

  task automatic test_random();
    logic [5:0] legal [15];
    logic [5:0] opc;
    int iw, dw;
    logic az;
    obs_t o, e;
    legal = '{OP_RTYPE, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI, OP_MOVE,
              OP_LW, OP_LB, OP_SW, OP_SB, OP_BEQ, OP_BNE, OP_J, OP_JAL};
    for (int n = 0; n < 60; n++) begin
      opc = legal[$urandom_range(0, 14)];
      iw  = $urandom_range(0, 3);
      dw  = $urandom_range(0, 3);
      az  = 1'($urandom);
      e   = model(opc, iw, dw, az);
      run_instr(opc, iw, dw, az, o);
      chks++; if (o.cyc !== e.cyc) begin errs++; $display("FAIL rnd_cycles op=%b iw=%0d dw=%0d got=%0d exp=%0d", opc, iw, dw, o.cyc, e.cyc); end
      chks++; if ({o.icyc, o.dcyc} !== {e.icyc, e.dcyc}) begin errs++; $display("FAIL rnd_reqs op=%b got i=%0d d=%0d exp i=%0d d=%0d", opc, o.icyc, o.dcyc, e.icyc, e.dcyc); end
      chks++; if ({o.we, o.byt} !== {e.we, e.byt}) begin errs++; $display("FAIL rnd_dmem op=%b got we=%b byte=%b exp we=%b byte=%b", opc, o.we, o.byt, e.we, e.byt); end
      chks++; if ({o.rw, o.rdst, o.wbs} !== {e.rw, e.rdst, e.wbs}) begin errs++; $display("FAIL rnd_wb op=%b got rw=%0d dst=%0d wb=%0d exp rw=%0d dst=%0d wb=%0d", opc, o.rw, o.rdst, o.wbs, e.rw, e.rdst, e.wbs); end
      chks++; if ({o.pcw, o.pcs} !== {e.pcw, e.pcs}) begin errs++; $display("FAIL rnd_pc op=%b az=%b got pcw=%0d src=%0d exp pcw=%0d src=%0d", opc, az, o.pcw, o.pcs, e.pcw, e.pcs); end
      chks++; if ({o.aop, o.asrc} !== {e.aop, e.asrc}) begin errs++; $display("FAIL rnd_alu op=%b got aop=%0d src=%b exp aop=%0d src=%b", opc, o.aop, o.asrc, e.aop, e.asrc); end
      chks++; if ({o.fetch_ok, o.trap} !== 2'b10) begin errs++; $display("FAIL rnd_fetch_trap op=%b got ok=%b trap=%b exp 1/0", opc, o.fetch_ok, o.trap); end
    end
  endtask

  // Ready arriving in the last allowed wait cycle still completes.
  task automatic test_wait_limit();
    obs_t o;
    run_instr(OP_SW, 3, 3, 1'b0, o);
    chks++; if ({o.cyc, o.trap} !== {32'd10, 1'b0}) begin errs++; $display("FAIL wait_limit got cyc=%0d trap=%b exp 10/0", o.cyc, o.trap); end
  endtask

  task automatic test_imem_timeout();
    int nreq;
    do_reset();
    nreq = 0;
    for (int n = 0; n < 20; n++) begin
      imem_ready = 1'b0; #1;
      if (trap) break;
      if (imem_req) nreq++;
      @(negedge clk);
    end
    chks++; if ({nreq, trap, trap_cause} !== {32'd4, 1'b1, CAUSE_IMEM})
      begin errs++; $display("FAIL imem_timeout got req=%0d trap=%b cause=%0d exp 4/1/2", nreq, trap, trap_cause); end
  endtask

  task automatic test_illegal();
    obs_t o;
    do_reset();
    run_instr(6'b111111, 0, 0, 1'b0, o);
    chks++; if ({o.trap, o.cause, o.cyc} !== {1'b1, CAUSE_ILLEGAL, 32'd3})
      begin errs++; $display("FAIL illegal got trap=%b cause=%0d cyc=%0d exp 1/1/3", o.trap, o.cause, o.cyc); end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      imem_ready = 1'($urandom); dmem_ready = 1'($urandom); opcode = OP_RTYPE;
      #1;
      chks++; if (outs !== {17'd0, 1'b1, CAUSE_ILLEGAL}) begin errs++; $display("FAIL trap_sticky cyc=%0d got=%h", n, outs); end
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic test_dmem_timeout();
    obs_t o;
    do_reset();
    run_instr(OP_SW, 0, 99, 1'b0, o);
    chks++; if ({o.dcyc, o.trap, o.cause} !== {32'd4, 1'b1, CAUSE_DMEM})
      begin errs++; $display("FAIL dmem_timeout got dreq=%0d trap=%b cause=%0d exp 4/1/3", o.dcyc, o.trap, o.cause); end
  endtask

  task automatic test_reset_mid_mem();
    obs_t o;
    do_reset();
    for (int n = 0; n < 10; n++) begin
      imem_ready = imem_req; dmem_ready = 1'b0; opcode = OP_SW;
      #1;
      if (dmem_req) break;
      @(negedge clk);
    end
    chks++; if (dmem_req !== 1'b1) begin errs++; $display("FAIL sw_reach_mem got=%b exp=1", dmem_req); end
    imem_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chks++; if (outs !== 20'd0) begin errs++; $display("FAIL mid_mem_reset got=%h exp=0", outs); end
    @(negedge clk); rst_n = 1'b1; #1;
    chks++; if (outs !== 20'd0) begin errs++; $display("FAIL post_reset_idle got=%h exp=0", outs); end
    @(negedge clk); #1;
    chks++; if (outs !== 20'h80000) begin errs++; $display("FAIL post_reset_fetch got=%h exp=80000", outs); end
    run_instr(OP_ADDI, 0, 0, 1'b0, o);
    chks++; if ({o.cyc, o.rw, o.aop, o.trap} !== {32'd4, 32'd1, ALU_ADD, 1'b0})
      begin errs++; $display("FAIL post_reset_addi got cyc=%0d rw=%0d aop=%0d trap=%b", o.cyc, o.rw, o.aop, o.trap); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lb();
    test_branch();
    test_jal();
    test_random();
    test_wait_limit();
    test_imem_timeout();
    test_illegal();
    test_dmem_timeout();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
